audio_i2s_tx: RTL and testbench



---
 rtl/audio_i2s_tx.sv | 174 +++++++++++++++++
 tb/tb_audio_i2s_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: single-clock I2S transmitter for the WM8731 DAC.
// Buffers 32-bit stereo samples {L,R} in a small FIFO, derives BCLK/LRCK
// from m_clock and shifts out 16-bit data in standard I2S framing
// (64 BCLKs per frame, one-BCLK data delay after each LRCK edge).
// Optional build macro: I2S_MONO_MIX_EN -- when defined, each popped sample
// is mixed to mono, (L+R)>>>1, and the result is played in both slots.
module audio_i2s_tx #(
    parameter int HALF_DIV = 12,
    parameter int FIFO_AW  = 2
) (
    input  logic               m_clock,
    input  logic               p_reset,
    input  logic               sample_valid,
    input  logic [31:0]        sample_data,
    input  logic               clr_status,
    output logic               frame_tick,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               underrun,
    output logic               overflow,
    output logic               aud_bclk,
    output logic               aud_lrck,
    output logic               aud_dacdat
);

    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [7:0]       DIV_LAST   = 8'(HALF_DIV - 1);
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]         div_cnt_reg;
    logic [5:0]         bit_cnt_reg;
    logic [5:0]         bit_cnt_next;
    logic               bclk_reg;
    logic               lrck_reg;
    logic               dacdat_reg;
    logic               tick_reg;
    logic               underrun_reg;
    logic               overflow_reg;
    logic [31:0]        frame_reg;
    logic [31:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   level_reg;
    logic [FIFO_AW:0]   level_next;

    logic               bclk_toggle;
    logic               bclk_fall;
    logic               frame_start;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [31:0]        head_word;
    logic [31:0]        load_word;
    logic [4:0]         bit_idx;
    logic               bit_active;
    logic               dacdat_next;

    // Divider terminal count, frame start and FIFO push/pop arbitration.
    // A pop in the same cycle frees a slot, so a push to a full FIFO is
    // accepted then; a pop on an empty FIFO never sees the same-cycle push.
    always_comb begin
        bclk_toggle  = (div_cnt_reg == DIV_LAST);
        bclk_fall    = bclk_toggle && bclk_reg;
        bit_cnt_next = bit_cnt_reg + 6'd1;
        frame_start  = bclk_fall && (bit_cnt_reg == 6'd63);
        fifo_empty   = (level_reg == '0);
        fifo_full    = (level_reg == LEVEL_FULL);
        pop          = frame_start && !fifo_empty;
        push         = sample_valid && (!fifo_full || pop);
        drop         = sample_valid && fifo_full && !pop;
        level_next   = level_reg + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    end

    assign head_word = fifo_mem[rd_ptr_reg];

`ifdef I2S_MONO_MIX_EN
    logic signed [16:0] mix_sum;

    // Mono mix: 17-bit signed sum of both channels, halved arithmetically.
    always_comb begin
        mix_sum   = $signed({head_word[31], head_word[31:16]})
                  + $signed({head_word[15], head_word[15:0]});
        load_word = {mix_sum[16:1], mix_sum[16:1]};
    end
`else
    assign load_word = head_word;
`endif

    // Serial bit select for the bit slot being entered on this falling edge:
    // slots 1..16 carry L MSB-first, 33..48 carry R MSB-first, others are 0.
    always_comb begin
        bit_active = 1'b0;
        bit_idx    = 5'd0;
        if (bit_cnt_next >= 6'd1 && bit_cnt_next <= 6'd16) begin
            bit_active = 1'b1;
            bit_idx    = 5'(6'd32 - bit_cnt_next);
        end else if (bit_cnt_next >= 6'd33 && bit_cnt_next <= 6'd48) begin
            bit_active = 1'b1;
            bit_idx    = 5'(6'd48 - bit_cnt_next);
        end
        dacdat_next = bit_active && frame_reg[bit_idx];
    end

    // FIFO storage: plain write port, no reset so it maps onto RAM.
    always_ff @(posedge m_clock) begin
        if (!p_reset && push) begin
            fifo_mem[wr_ptr_reg] <= sample_data;
        end
    end

    // Clock generation, serializer, FIFO pointers and sticky status.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= 6'd63;
            bclk_reg     <= 1'b0;
            lrck_reg     <= 1'b0;
            dacdat_reg   <= 1'b0;
            tick_reg     <= 1'b0;
            underrun_reg <= 1'b0;
            overflow_reg <= 1'b0;
            frame_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
        end else begin
            tick_reg <= frame_start;

            if (bclk_toggle) begin
                div_cnt_reg <= '0;
                bclk_reg    <= ~bclk_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg + 8'd1;
            end

            if (bclk_fall) begin
                bit_cnt_reg <= bit_cnt_next;
                lrck_reg    <= bit_cnt_next[5];
                dacdat_reg  <= dacdat_next;
            end

            if (pop) begin
                frame_reg  <= load_word;
                rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            end
            level_reg <= level_next;

            if (frame_start && fifo_empty) begin
                underrun_reg <= 1'b1;
            end else if (clr_status) begin
                underrun_reg <= 1'b0;
            end

            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_status) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign frame_tick = tick_reg;
    assign fifo_level = level_reg;
    assign underrun   = underrun_reg;
    assign overflow   = overflow_reg;
    assign aud_bclk   = bclk_reg;
    assign aud_lrck   = lrck_reg;
    assign aud_dacdat = dacdat_reg;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed bench for audio_i2s_tx at HALF_DIV=12, FIFO_AW=2.
// Expected slot values follow I2S_MONO_MIX_EN when the bench is built with it.
module tb_audio_i2s_tx;

    localparam int HD  = 12;
    localparam int FAW = 2;

    logic           m_clock      = 1'b0;
    logic           p_reset      = 1'b1;
    logic           sample_valid = 1'b0;
    logic [31:0]    sample_data  = '0;
    logic           clr_status   = 1'b0;
    logic           frame_tick;
    logic [FAW:0]   fifo_level;
    logic           underrun;
    logic           overflow;
    logic           aud_bclk;
    logic           aud_lrck;
    logic           aud_dacdat;

    audio_i2s_tx #(.HALF_DIV(HD), .FIFO_AW(FAW)) dut (
        .m_clock      (m_clock),
        .p_reset      (p_reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .clr_status   (clr_status),
        .frame_tick   (frame_tick),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .overflow     (overflow),
        .aud_bclk     (aud_bclk),
        .aud_lrck     (aud_lrck),
        .aud_dacdat   (aud_dacdat)
    );

    always #5 m_clock = ~m_clock;

    // Sample table: 0 = first-frame sample, 1..5 = burst A0..A4, 6 = push-at-tick sample.
    logic [31:0] smp [7] = '{32'h8001_7FFE, 32'h1111_2222, 32'h8000_7FFF, 32'h7FFF_7FFF,
                             32'h5555_6666, 32'h9999_AAAA, 32'h1234_5678};
`ifdef I2S_MONO_MIX_EN
    logic [15:0] exp_l [7] = '{16'hFFFF, 16'h1999, 16'hFFFF, 16'h7FFF, 16'h5DDD, 16'hA221, 16'h3456};
    logic [15:0] exp_r [7] = '{16'hFFFF, 16'h1999, 16'hFFFF, 16'h7FFF, 16'h5DDD, 16'hA221, 16'h3456};
`else
    logic [15:0] exp_l [7] = '{16'h8001, 16'h1111, 16'h8000, 16'h7FFF, 16'h5555, 16'h9999, 16'h1234};
    logic [15:0] exp_r [7] = '{16'h7FFE, 16'h2222, 16'h7FFF, 16'h7FFF, 16'h6666, 16'hAAAA, 16'h5678};
`endif

    int     n_vec = 0;
    int     n_bad = 0;
    longint cyc   = 0;
    longint last_tick = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("  ok %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge m_clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        p_reset      = 1'b1;
        sample_valid = 1'b0;
        clr_status   = 1'b0;
        repeat (3) step();
        p_reset = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int waited = 0;
        do begin
            step();
            waited++;
        end while (!frame_tick && waited < 4000);
        check_val(tag, {31'd0, frame_tick}, 32'd1);
        last_tick = cyc;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
    endtask

    // Called right after a frame_tick: follows BCLK, samples data on rising edges.
    task automatic capture(output logic [15:0] l, output logic [15:0] r,
                           output int zbits, output int lrbad);
        int   bc = 0;
        int   k  = 0;
        logic prev;
        l = '0; r = '0; zbits = 0; lrbad = 0;
        prev = aud_bclk;
        while (bc < 50 && k < 128 * HD + 10) begin
            step();
            k++;
            if (prev && !aud_bclk) bc++;
            if (!prev && aud_bclk) begin
                if (bc >= 1 && bc <= 16)       l = {l[14:0], aud_dacdat};
                else if (bc >= 33 && bc <= 48) r = {r[14:0], aud_dacdat};
                else                           zbits += int'(aud_dacdat);
                if (aud_lrck !== (bc >= 32)) lrbad++;
            end
            prev = aud_bclk;
        end
        if (bc < 50) lrbad += 1000;
    endtask

    task automatic check_frame(input string tag, input int idx);
        logic [15:0] l, r;
        int zb, lb;
        capture(l, r, zb, lb);
        check_val({tag, "_L"}, {16'd0, l}, {16'd0, exp_l[idx]});
        check_val({tag, "_R"}, {16'd0, r}, {16'd0, exp_r[idx]});
        check_val({tag, "_zero_bits"}, zb, 0);
        check_val({tag, "_lrck"}, lb, 0);
    endtask

    initial begin
        int rise_i, fall_i, tick_i, ticks, ur_at_tick;
        longint t0;

        // ---- Reset state and first-frame timing ----
        do_reset();
        check_val("rst_bclk",   {31'd0, aud_bclk},   32'd0);
        check_val("rst_lrck",   {31'd0, aud_lrck},   32'd0);
        check_val("rst_dacdat", {31'd0, aud_dacdat}, 32'd0);
        check_val("rst_tick",   {31'd0, frame_tick}, 32'd0);
        check_val("rst_level",  {29'd0, fifo_level}, 32'd0);
        check_val("rst_underrun", {31'd0, underrun}, 32'd0);
        check_val("rst_overflow", {31'd0, overflow}, 32'd0);

        rise_i = -1; fall_i = -1; tick_i = -1; ticks = 0; ur_at_tick = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rise_i < 0 && aud_bclk) rise_i = i;
            if (rise_i >= 0 && fall_i < 0 && !aud_bclk) fall_i = i;
            if (frame_tick) begin
                ticks++;
                if (tick_i < 0) begin
                    tick_i = i;
                    ur_at_tick = int'(underrun);
                    last_tick = cyc;
                end
            end
        end
        check_val("first_rise",    rise_i, 11);
        check_val("first_fall",    fall_i, 23);
        check_val("first_tick",    tick_i, 23);
        check_val("tick_width",    ticks, 1);
        check_val("underrun_empty", ur_at_tick, 1);
        t0 = last_tick;
        wait_tick("tick2_seen");
        check_val("frame_period1", 32'(last_tick - t0), 32'd1536);
        t0 = last_tick;
        wait_tick("tick3_seen");
        check_val("frame_period2", 32'(last_tick - t0), 32'd1536);
        pulse_clr();
        check_val("clr_underrun", {31'd0, underrun}, 32'd0);

        // ---- One sample before the first frame start ----
        do_reset();
        sample_valid = 1'b1;
        sample_data  = smp[0];
        step();
        sample_valid = 1'b0;
        check_val("push_level1", {29'd0, fifo_level}, 32'd1);
        wait_tick("f0_tick");
        check_val("f0_underrun", {31'd0, underrun},   32'd0);
        check_val("f0_level",    {29'd0, fifo_level}, 32'd0);
        check_frame("f0", 0);
        wait_tick("f1_tick");
        check_val("f1_underrun", {31'd0, underrun}, 32'd1);
        check_frame("f1_repeat", 0);
        pulse_clr();

        // ---- Burst of five pushes into a 4-deep FIFO ----
        for (int j = 0; j < 5; j++) begin
            sample_valid = 1'b1;
            sample_data  = smp[1 + j];
            step();
            $display("  push 0x%08h level=%0d overflow=%0b", smp[1 + j], fifo_level, overflow);
            if (j == 3) check_val("full_no_ovf", {31'd0, overflow}, 32'd0);
        end
        sample_valid = 1'b0;
        check_val("burst_level",    {29'd0, fifo_level}, 32'd4);
        check_val("burst_overflow", {31'd0, overflow},   32'd1);
        pulse_clr();
        check_val("clr_overflow",   {31'd0, overflow},   32'd0);
        check_val("clr_keeps_level", {29'd0, fifo_level}, 32'd4);

        // ---- Push while full exactly on the frame start edge ----
        while (cyc < last_tick + 1535) step();
        sample_valid = 1'b1;
        sample_data  = smp[6];
        step();
        sample_valid = 1'b0;
        last_tick = cyc;
        check_val("tickpush_tick",     {31'd0, frame_tick}, 32'd1);
        check_val("tickpush_level",    {29'd0, fifo_level}, 32'd4);
        check_val("tickpush_overflow", {31'd0, overflow},   32'd0);
        check_val("tickpush_underrun", {31'd0, underrun},   32'd0);
        check_frame("play_a0", 1);
        wait_tick("a1_tick");
        check_frame("play_a1", 2);
        wait_tick("a2_tick");
        check_frame("play_a2", 3);
        wait_tick("a3_tick");
        check_frame("play_a3", 4);
        wait_tick("b_tick");
        check_val("b_level",    {29'd0, fifo_level}, 32'd0);
        check_val("b_underrun", {31'd0, underrun},   32'd0);
        check_frame("play_b", 6);

        // ---- Starvation repeats the last sample ----
        wait_tick("starve_tick");
        check_val("starve_underrun", {31'd0, underrun}, 32'd1);
        check_frame("starve_repeat", 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
